// File: rtl/truth_table_sweeper_if.sv
// Control-side bundle between the test/config controller (master) and truth_table_sweeper (slave).
// The measured table is carried as meas_table because "table" is a reserved word.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
) ();
    localparam int TT = 2 ** N_IN;

    logic            start;
    logic            abort;
    logic [TT-1:0]   expected;
    logic            busy;
    logic            done;
    logic [TT-1:0]   meas_table;
    logic            match;
    logic [N_IN:0]   mismatch_cnt;

    modport master (
        output start, abort, expected,
        input  busy, done, meas_table, match, mismatch_cnt
    );

    modport slave (
        input  start, abort, expected,
        output busy, done, meas_table, match, mismatch_cnt
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for an N_IN-input, 1-output combinational gate.
// Define SWEEP_GRAY_EN to step input vectors in Gray order instead of binary order.
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_sweeper_if.slave     ctl,
    output logic [N_IN-1:0]          dut_in,
    input  logic                     dut_out
);
    localparam int TT = 2 ** N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t            state, state_nx;
    logic [N_IN-1:0]   idx, idx_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [TT-1:0]     exp_q, exp_nx;
    logic [TT-1:0]     tbl, tbl_nx;
    logic              match_q, match_nx;
    logic [N_IN:0]     mcnt, mcnt_nx;
    logic [N_IN-1:0]   vec;

    function automatic logic [N_IN:0] popcount(input logic [TT-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int unsigned i = 0; i < TT; i++) begin
            c = c + (N_IN+1)'(v[i]);
        end
        return c;
    endfunction

`ifdef SWEEP_GRAY_EN
    assign vec = idx ^ (idx >> 1);
`else
    assign vec = idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            exp_q   <= '0;
            tbl     <= '0;
            match_q <= 1'b0;
            mcnt    <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            exp_q   <= exp_nx;
            tbl     <= tbl_nx;
            match_q <= match_nx;
            mcnt    <= mcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        exp_nx   = exp_q;
        tbl_nx   = tbl;
        match_nx = match_q;
        mcnt_nx  = mcnt;
        case (state)
            IDLE: begin
                if (ctl.start) begin
                    exp_nx   = ctl.expected;
                    tbl_nx   = '0;
                    match_nx = 1'b0;
                    mcnt_nx  = '0;
                    idx_nx   = '0;
                    cnt_nx   = RELOAD;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                // abort wins over a sample landing on the same edge
                if (ctl.abort) begin
                    state_nx = IDLE;
                    match_nx = 1'b0;
                    mcnt_nx  = '0;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    tbl_nx[vec] = dut_out;
                    if (idx == LAST_IDX) begin
                        // verdict taken from the table including this final sample
                        match_nx = (tbl_nx == exp_q);
                        mcnt_nx  = popcount(tbl_nx ^ exp_q);
                        idx_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        idx_nx = idx + 1'b1;
                        cnt_nx = RELOAD;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign dut_in           = (state == SETTLE) ? vec : '0;
    assign ctl.busy         = (state == SETTLE);
    assign ctl.done         = (state == DONE);
    assign ctl.meas_table   = tbl;
    assign ctl.match        = match_q;
    assign ctl.mismatch_cnt = mcnt;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed and randomized checks of truth_table_sweeper against a table-level reference model.
module tb_truth_table_sweeper;
    logic       clk;
    logic       rst_n;
    logic [2:0] dut_in;
    logic       dut_out;
    logic [7:0] gate_tt;

    int n_checks = 0;
    int n_err    = 0;

    truth_table_sweeper_if #(.N_IN(3)) bus ();

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (bus.slave),
        .dut_in  (dut_in),
        .dut_out (dut_out)
    );

    // gate under evaluation: arbitrary 3-input function given by gate_tt
    assign dut_out = gate_tt[dut_in];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k-th vector applied during a sweep
    function automatic logic [2:0] order(input int k);
        logic [2:0] b;
        b = k[2:0];
`ifdef SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Full sweep; optional re-pulse of start with a different expected in cycle repulse_cyc.
    task automatic run_sweep(input logic [7:0] exp, input int repulse_cyc, input string tag);
        logic [7:0] want_tbl;
        want_tbl = gate_tt;
        bus.expected = exp;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
            chk({tag, "_dut_in"}, 32'(dut_in), 32'(order((c - 1) / 4)));
            if (c == repulse_cyc) begin
                bus.expected = ~exp;
                bus.start    = 1'b1;
            end
            tick();
            bus.start = 1'b0;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, "_dut_in_end"}, 32'(dut_in), 32'd0);
        chk({tag, "_table"}, 32'(bus.meas_table), 32'(want_tbl));
        chk({tag, "_match"}, 32'(bus.match), 32'(want_tbl == exp));
        chk({tag, "_mcnt"}, 32'(bus.mismatch_cnt), 32'($countones(want_tbl ^ exp)));
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_match_hold"}, 32'(bus.match), 32'(want_tbl == exp));
    endtask

    initial begin
        logic       saw_done;
        logic [7:0] rexp;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = '0;
        gate_tt      = 8'h96;
        tick();
        tick();
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_table", 32'(bus.meas_table), 32'd0);
        chk("rst_match", 32'(bus.match), 32'd0);
        chk("rst_mcnt",  32'(bus.mismatch_cnt), 32'd0);
        chk("rst_dutin", 32'(dut_in), 32'd0);
        rst_n = 1'b1;
        tick();

        // XOR gate, matching and inverted expectations
        gate_tt = 8'h96;
        run_sweep(8'h96, 0, "xor_pass");
        run_sweep(8'h69, 0, "xor_inv");

        // stuck-at-1 gate
        gate_tt = 8'hFF;
        run_sweep(8'hE1, 0, "stuck1");

        // abort in cycle 10: vectors 0 and 1 already sampled
        bus.expected = 8'h00;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy",  32'(bus.busy), 32'd0);
        chk("abort_table", 32'(bus.meas_table), 32'h03);
        chk("abort_match", 32'(bus.match), 32'd0);
        chk("abort_mcnt",  32'(bus.mismatch_cnt), 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        gate_tt = 8'h96;
        run_sweep(8'h96, 0, "after_abort");

        // start re-pulsed mid-sweep with another expected is ignored
        run_sweep(8'h96, 5, "repulse");

        // reset in cycle 20 of a sweep
        bus.expected = 8'h96;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  32'(bus.busy), 32'd0);
        chk("midrst_done",  32'(bus.done), 32'd0);
        chk("midrst_table", 32'(bus.meas_table), 32'd0);
        chk("midrst_match", 32'(bus.match), 32'd0);
        chk("midrst_mcnt",  32'(bus.mismatch_cnt), 32'd0);
        chk("midrst_dutin", 32'(dut_in), 32'd0);
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        chk("midrst_no_done", 32'(saw_done), 32'd0);

        // randomized gates and expectations
        for (int r = 0; r < 6; r++) begin
            gate_tt = 8'($urandom);
            rexp    = ($urandom_range(0, 2) == 0) ? gate_tt : 8'($urandom);
            run_sweep(rexp, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises a 3-input, 1-output combinational logic gate (case-statement truth-table module).
- Drives every input combination in turn, waits a programmable settle time, samples the gate output and assembles the measured truth table.
- Compares the measured table against an expected table and reports pass/fail plus the mismatch count.
- Sits between the test/config controller and the gate under evaluation.

Parameters:
- N_IN, 3, number of gate inputs; truth-table width TT = 2**N_IN (8 at default).
- SETTLE_CYCLES, 4, cycles each input vector is held before sampling; legal range ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected  input  TT  expected table, bit k = output for input vector k; latched on accepted start.
- dut_in  output  N_IN  drives gate inputs; MSB = in1, LSB = in3.
- dut_out  input  1  gate output.
- busy  output  1  high from the cycle after accepted start until the sweep ends.
- done  output  1  one-cycle pulse, sweep complete.
- table  output  TT  measured table, bit k = sampled dut_out for vector k.
- match  output  1  table == expected; valid with done, held until next accepted start.
- mismatch_cnt  output  N_IN+1  popcount(table ^ expected); same validity as match.

Behaviour:
- Reset (async assert, sync release): state IDLE; dut_in=0, busy=0, done=0, table=0, match=0, mismatch_cnt=0, internal idx/settle counter=0.
- States: IDLE, SETTLE, DONE.
- IDLE: dut_in=0. start=1 → latch expected; clear table, match, mismatch_cnt; idx=0; settle counter=SETTLE_CYCLES-1; go SETTLE next cycle (busy=1, dut_in=vector(0)).
- SETTLE: dut_in=vector(idx), stable. Counter decrements each cycle. When counter==0, on that edge:
  - table[vector(idx)] ← dut_out.
  - idx==TT-1 → go DONE.
  - Otherwise idx+1 and counter reloaded to SETTLE_CYCLES-1.
- vector(idx) = idx (binary order) unless the optional feature is enabled.
- DONE: one cycle. done=1, busy=0, match and mismatch_cnt registered from the final table, dut_in returns to 0. Next state IDLE.
- Latency: start sampled at edge 0 → done high in cycle TT*SETTLE_CYCLES+1 (33 at defaults). Back-to-back: start may be accepted in the cycle after done.
- start while busy or in DONE: ignored; expected is not re-latched.
- abort in SETTLE: next state IDLE, busy=0 next cycle, no done pulse. table keeps partial samples; match=0, mismatch_cnt=0. abort has priority over a same-cycle sample. Ignored in IDLE/DONE.
- start and abort both high in IDLE: start accepted.
- dut_out is treated as synchronous to clk; the block adds no synchronizer.
- Reset mid-sweep: immediate return to reset values, no done.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined: vector(idx) = idx ^ (idx >> 1), giving Gray order (0,1,3,2,6,7,5,4 at N_IN=3). Only one gate input toggles per step, limiting glitch-induced mis-samples. table is still indexed by the binary vector value, so results are identical to binary order for a correct gate.
- Undefined: binary order 0..TT-1.

Test Plan:
- Gate model out=in1^in2^in3, expected=8'h96, start pulse → done exactly in cycle 33 after the start edge; table=8'h96, match=1, mismatch_cnt=0; busy high cycles 1–32.
- Same model, expected=8'h69 → table=8'h96, match=0, mismatch_cnt=8.
- Gate model stuck-at-1, expected=8'hE1 → table=8'hFF, match=0, mismatch_cnt=4. Check dut_in holds each vector for 4 cycles, in binary order 0..7.
- abort asserted in cycle 10 of a sweep → busy=0 in cycle 11; no done; table bits 0..1 sampled, rest 0; match=0. A new start then completes normally.
- start re-pulsed in cycle 5 with a different expected → ignored; result uses the original expected. rst_n low in cycle 20 → all outputs 0 at once, no done.
- With SWEEP_GRAY_EN, XOR model → dut_in sequence 0,1,3,2,6,7,5,4; table=8'h96, match=1, done in cycle 33.
